// File: rtl/alu_stream_pkg.sv
// Shared definitions for the ALU result stream path: byte width, FIFO read latency
// and the serializer state encoding.
package alu_stream_pkg;

    localparam int BYTE_W          = 8;
    localparam int FIFO_RD_LATENCY = 1;

    localparam logic [2:0] SER_IDLE = 3'd0;
    localparam logic [2:0] SER_GET  = 3'd1;
    localparam logic [2:0] SER_LOAD = 3'd2;
    localparam logic [2:0] SER_SEND = 3'd3;
    localparam logic [2:0] SER_CSUM = 3'd4;
    localparam logic [2:0] SER_DONE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = SER_IDLE,
        S_GET  = SER_GET,
        S_LOAD = SER_LOAD,
        S_SEND = SER_SEND,
        S_CSUM = SER_CSUM,
        S_DONE = SER_DONE
    } ser_state_e;

endpackage

// File: rtl/result_serializer.sv
// Pops result words from the ALU result FIFO and streams them MSB-first as bytes over a
// valid/ready handshake, optionally followed by an XOR checksum byte per word.
module result_serializer
    import alu_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter bit CHECKSUM_EN = 1'b1,
    parameter int COUNT_W     = 16
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  empty_i,
    output logic                  rd_o,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [BYTE_W-1:0]     tx_data_o,
    output logic                  busy_o,
    output logic [COUNT_W-1:0]    words_sent_o
);

    localparam int NBYTES = DATA_WIDTH / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
        $error("result_serializer: DATA_WIDTH must be a multiple of 8");
    end
    if (FIFO_RD_LATENCY != 1) begin : g_bad_latency
        $error("result_serializer: GET/LOAD sequence assumes a one-cycle FIFO read latency");
    end

    ser_state_e            state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BYTE_W-1:0]     csum_q;
    logic [BYTE_W-1:0]     tx_data_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  rd_q;
    logic                  tx_valid_q;
    logic                  busy_q;
    logic [COUNT_W-1:0]    words_sent_q;

    logic [DATA_WIDTH-1:0] shift_d;
    logic [BYTE_W-1:0]     csum_d;
    logic                  tx_fire;

    // shift_q holds only the bytes not yet presented, so its top byte is always the next one out.
    assign tx_fire = tx_valid_q && tx_ready_i;
    assign shift_d = shift_q << BYTE_W;
    assign csum_d  = csum_q ^ tx_data_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            csum_q       <= '0;
            tx_data_q    <= '0;
            idx_q        <= '0;
            rd_q         <= 1'b0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            words_sent_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty_i) begin
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_GET;
                    end
                end
                S_GET: begin
                    rd_q    <= 1'b0;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    shift_q    <= din_i << BYTE_W;
                    csum_q     <= '0;
                    idx_q      <= '0;
                    tx_data_q  <= din_i[DATA_WIDTH-1 -: BYTE_W];
                    tx_valid_q <= 1'b1;
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    if (tx_fire) begin
                        csum_q <= csum_d;
                        if (idx_q != LAST_IDX) begin
                            idx_q     <= idx_q + IDX_W'(1);
                            shift_q   <= shift_d;
                            tx_data_q <= shift_q[DATA_WIDTH-1 -: BYTE_W];
                        end else if (CHECKSUM_EN) begin
                            tx_data_q <= csum_d;
                            state_q   <= S_CSUM;
                        end else begin
                            // Drop valid on the accepting edge so DONE never re-offers the last byte.
                            tx_valid_q <= 1'b0;
                            state_q    <= S_DONE;
                        end
                    end
                end
                S_CSUM: begin
                    if (tx_fire) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    tx_valid_q   <= 1'b0;
                    words_sent_q <= words_sent_q + COUNT_W'(1);
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    rd_q       <= 1'b0;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_o         = rd_q;
    assign tx_valid_o   = tx_valid_q;
    assign tx_data_o    = tx_data_q;
    assign busy_o       = busy_q;
    assign words_sent_o = words_sent_q;

endmodule
